ps2_rx_fifo_receiver: RTL and testbench

Parametrised PS/2 device-to-host receiver. It synchronises and filters the PS/2 clock and data lines, deframes 11-bit frames (start, 8 data LSB first, odd parity, stop), and buffers good bytes in an internal FIFO. Consumers read bytes through a ready/valid port. Parity, framing and overflow errors are reported as one-cycle pulses. It sits between the keyboard pins and the scan-code decoder in the central unit.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_byte_fifo.sv | 93 +++++++++
 rtl/ps2_rx_fifo_receiver.sv | 190 +++++++++++++++++++
 tb/tb_ps2_rx_fifo_receiver.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 receive path.
//   - ps2_state_e : deframer state (idle, data bits, parity bit, stop bit)
//   - FRAME_BITS  : bits per PS/2 frame (start + 8 data + parity + stop)
//   - DATA_BITS   : payload width
//   - odd_parity  : parity bit that makes the total count of ones odd
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo: small byte FIFO with a registered head output.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   push_i, push_data_i write request and byte
//   push_accept_o       push is taken this cycle (not full, or a pop frees a slot)
//   pop_i               consumer takes the head byte this cycle
//   valid_o             FIFO non-empty (registered)
//   head_o              head byte (registered)
//   count_o             bytes held
module ps2_byte_fifo #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned WIDTH      = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             push_i,
    input  logic [WIDTH-1:0]                 push_data_i,
    output logic                             push_accept_o,
    input  logic                             pop_i,
    output logic                             valid_o,
    output logic [WIDTH-1:0]                 head_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             do_pop, accept;

    assign do_pop = pop_i && valid_q;
    // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts.
    assign accept = push_i && ((count_q < CntW'(FIFO_DEPTH)) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (accept) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            head_d   = mem_q[rd_ptr_q + PtrW'(1)];
        end
        // Incoming byte becomes the head when nothing else will be stored ahead of it.
        if (accept && ((count_q == '0) || ((count_q == CntW'(1)) && do_pop))) begin
            head_d = push_data_i;
        end

        unique case ({accept, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign push_accept_o = accept;
    assign valid_o       = valid_q;
    assign head_o        = head_q;
    assign count_o       = count_q;

endmodule

// File: rtl/ps2_rx_fifo_receiver.sv
// ps2_rx_fifo_receiver: PS/2 device-to-host receiver with byte FIFO.
// Synchronises and filters the PS/2 clock, deframes 11-bit frames (start, 8 data
// LSB first, odd parity, stop) and buffers good bytes for a ready/valid consumer.
// Optional build macro: PS2_RX_TIMEOUT_EN adds a watchdog that aborts stalled frames.
// Ports:
//   clock, reset          system clock, asynchronous active-low reset
//   ps2_clock, ps2_data   raw PS/2 pins
//   out_valid/out_ready   consumer handshake, out_data is the FIFO head byte
//   fifo_count            bytes held
//   parity_err, frame_err, overflow, timeout_err  one-cycle error pulses
module ps2_rx_fifo_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 5,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             ps2_clock,
    input  logic                             ps2_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_BITS-1:0]             out_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             parity_err,
    output logic                             frame_err,
    output logic                             overflow,
    output logic                             timeout_err
);

    localparam int unsigned HistW   = 2 * FILTER_LEN;
    localparam int unsigned BitCntW = $clog2(FRAME_BITS);

    logic [1:0]           clk_sync_q, clk_sync_d;
    logic [1:0]           dat_sync_q, dat_sync_d;
    logic [HistW-1:0]     hist_q, hist_d;
    ps2_state_e           state_q, state_d;
    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 ovf_q, ovf_d;
    logic                 fall_pulse, bit_in, tmo_hit;
    logic                 push, push_accept, pop;

    // Newest sample enters at bit 0; the older half must be a clean high run.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clock};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        hist_d     = {hist_q[HistW-2:0], clk_sync_q[1]};
    end

    assign bit_in     = dat_sync_q[1];
    assign fall_pulse = (hist_q[FILTER_LEN-1:0] == '0) && (&hist_q[HistW-1:FILTER_LEN]);

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           tmo_err_q;

    always_comb begin
        if (fall_pulse || (state_q == ST_IDLE)) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WdW'(1);
        end
    end

    // A real edge arriving on the deadline wins over the watchdog.
    assign tmo_hit = !fall_pulse && (state_q != ST_IDLE) && (wd_q == WdW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_q      <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            tmo_err_q <= tmo_hit;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    // Watchdog not built: the timeout length has no effect on this variant.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo_hit            = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        push      = 1'b0;

        if (fall_pulse) begin
            unique case (state_q)
                ST_IDLE: begin
                    // A high start bit is a spurious edge and is ignored.
                    if (!bit_in) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {bit_in, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    if (bit_cnt_q == BitCntW'(DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = bit_in;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!bit_in) begin
                        frm_err_d = 1'b1;
                    end else if (parity_q != odd_parity(shift_q)) begin
                        par_err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
        end

        ovf_d = push && !push_accept;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            hist_q     <= '1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            hist_q     <= hist_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign pop = out_valid && out_ready;

    ps2_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (DATA_BITS)
    ) u_fifo (
        .clk_i         (clock),
        .rst_ni        (reset),
        .push_i        (push),
        .push_data_i   (shift_q),
        .push_accept_o (push_accept),
        .pop_i         (pop),
        .valid_o       (out_valid),
        .head_o        (out_data),
        .count_o       (fifo_count)
    );

    assign parity_err = par_err_q;
    assign frame_err  = frm_err_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo_receiver.sv
module tb_ps2_rx_fifo_receiver;

    localparam int unsigned FL    = 5;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 5000;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clock;
    logic       ps2_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] fifo_count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic       timeout_err;

    ps2_rx_fifo_receiver #(
        .FILTER_LEN     (FL),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ps2_clock   (ps2_clock),
        .ps2_data    (ps2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .fifo_count  (fifo_count),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_par = 0, n_frm = 0, n_ovf = 0, n_tmo = 0, n_vld = 0;
    int s_par, s_frm, s_ovf, s_tmo, s_vld;

    logic [7:0] popped[$];
    logic [7:0] exp_pops[$];
    logic [7:0] mq[$];

    // Monitor away from the active edge: pulse counts and accepted bytes.
    always @(negedge clock) begin
        if (parity_err)  n_par++;
        if (frame_err)   n_frm++;
        if (overflow)    n_ovf++;
        if (timeout_err) n_tmo++;
        if (out_valid)   n_vld++;
        if (out_valid && out_ready) popped.push_back(out_data);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic snap();
        s_par = n_par; s_frm = n_frm; s_ovf = n_ovf; s_tmo = n_tmo; s_vld = n_vld;
    endtask

    task automatic chk_pulses(input string tag, input int ep, input int ef, input int eo,
                              input int et);
        chk({tag, ".parity_err"},  n_par - s_par, ep);
        chk({tag, ".frame_err"},   n_frm - s_frm, ef);
        chk({tag, ".overflow"},    n_ovf - s_ovf, eo);
        chk({tag, ".timeout_err"}, n_tmo - s_tmo, et);
    endtask

    function automatic logic [10:0] build(input logic [7:0] d, input bit pb, input bit sb);
        logic [10:0] f;
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ((ones % 2) == 0) ^ pb;   // odd total when pb=0
        f[10] = !sb;
        return f;
    endfunction

    // Drive bits lo..hi. pop_idx: pulse out_ready in the cycle the bit's filtered edge
    // is expected (2+FL cycles after the pin falls). glitch_idx: short low glitch first.
    task automatic send_bits(input logic [10:0] f, input int lo, input int hi,
                             input int pop_idx, input int glitch_idx);
        for (int i = lo; i <= hi; i++) begin
            if (i == glitch_idx) begin
                tick(2);
                ps2_clock = 1'b0;
                tick(FL - 1);
                ps2_clock = 1'b1;
                tick(FL + 3);
            end
            ps2_data = f[i];
            tick(10);
            ps2_clock = 1'b0;
            if (i == pop_idx) begin
                tick(2 + FL);
                out_ready = 1'b1;
                tick(1);
                out_ready = 1'b0;
                tick(20 - 3 - FL);
            end else begin
                tick(20);
            end
            ps2_clock = 1'b1;
            tick(10);
        end
        ps2_data = 1'b1;
    endtask

    // Reference: classify the frame and apply FIFO accept/drop rules to the byte queue.
    task automatic model_frame(input logic [7:0] d, input bit pb, input bit sb, input bit pop_stop,
                               output int ep, output int ef, output int eo);
        ep = 0; ef = 0; eo = 0;
        if (pop_stop) exp_pops.push_back(mq.pop_front());
        if (sb) ef = 1;
        else if (pb) ep = 1;
        else if (mq.size() < DEPTH) begin
            mq.push_back(d);
            if (out_ready) exp_pops.push_back(mq.pop_front());
        end else eo = 1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input bit pb, input bit sb,
                             input bit pop_stop, input int glitch_idx);
        int ep, ef, eo;
        snap();
        if (out_ready) while (mq.size() > 0) exp_pops.push_back(mq.pop_front());
        send_bits(build(d, pb, sb), 0, 10, pop_stop ? 10 : -1, glitch_idx);
        tick(3);
        model_frame(d, pb, sb, pop_stop, ep, ef, eo);
        chk_pulses(tag, ep, ef, eo, 0);
        chk({tag, ".fifo_count"}, fifo_count, mq.size());
        chk({tag, ".out_valid"}, out_valid, mq.size() != 0);
        if (mq.size() != 0) chk({tag, ".out_data"}, out_data, mq[0]);
    endtask

    task automatic check_pops(input string tag);
        chk({tag, ".pop_count"}, popped.size(), exp_pops.size());
        for (int i = 0; i < popped.size() && i < exp_pops.size(); i++)
            chk($sformatf("%s.pop[%0d]", tag, i), popped[i], exp_pops[i]);
        popped.delete();
        exp_pops.delete();
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick(DEPTH + 4);
        while (mq.size() > 0) exp_pops.push_back(mq.pop_front());
        out_ready = 1'b0;
        tick(2);
        check_pops(tag);
        chk({tag, ".fifo_count"}, fifo_count, 0);
        chk({tag, ".out_valid"}, out_valid, 0);
    endtask

    initial begin
        int ep, ef, eo;
        reset     = 1'b0;
        ps2_clock = 1'b1;
        ps2_data  = 1'b1;
        out_ready = 1'b0;
        tick(3);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_data", out_data, 0);
        chk("rst.fifo_count", fifo_count, 0);
        chk("rst.pulses", {parity_err, frame_err, overflow, timeout_err}, 0);
        reset = 1'b1;
        tick(30);
        chk("rst_rel.no_edge", n_par + n_frm + n_ovf + n_tmo + n_vld, 0);

        // Good byte straight through to a ready consumer.
        out_ready = 1'b1;
        run_frame("good_1c", 8'h1C, 1'b0, 1'b0, 1'b0, -1);
        chk("good_1c.valid_cycles", n_vld - s_vld, 1);
        check_pops("good_1c");
        run_frame("par_1c", 8'h1C, 1'b1, 1'b0, 1'b0, -1);
        run_frame("frm_1c", 8'h1C, 1'b1, 1'b1, 1'b0, -1);
        check_pops("errs_1c");

        // Fill past capacity with the consumer stalled.
        out_ready = 1'b0;
        for (int b = 1; b <= 9; b++) run_frame($sformatf("fill_%0d", b), 8'(b), 1'b0, 1'b0, 1'b0, -1);
        // Full FIFO, pop coincides with the good stop bit.
        run_frame("full_pop", 8'h0A, 1'b0, 1'b0, 1'b1, -1);
        drain("drain_full");

        // Short clock glitch mid-frame must not count as a bit.
        out_ready = 1'b1;
        run_frame("glitch", 8'hA5, 1'b0, 1'b0, 1'b0, 4);
        check_pops("glitch");

`ifdef PS2_RX_TIMEOUT_EN
        snap();
        send_bits(build(8'hB3, 1'b0, 1'b0), 0, 4, -1, -1);
        tick(TMO + 100);
        chk_pulses("timeout", 0, 0, 0, 1);
        chk("timeout.fifo_count", fifo_count, 0);
        run_frame("after_tmo", 8'hF0, 1'b0, 1'b0, 1'b0, -1);
        check_pops("after_tmo");
`else
        // Without the watchdog a stalled frame resumes when edges return.
        snap();
        send_bits(build(8'hB3, 1'b0, 1'b0), 0, 4, -1, -1);
        tick(300);
        chk_pulses("stall", 0, 0, 0, 0);
        chk("stall.fifo_count", fifo_count, 0);
        send_bits(build(8'hB3, 1'b0, 1'b0), 5, 10, -1, -1);
        tick(3);
        model_frame(8'hB3, 1'b0, 1'b0, 1'b0, ep, ef, eo);
        chk_pulses("resume", ep, ef, eo, 0);
        check_pops("resume");
`endif

        // Randomised frames, errors and consumer stalls.
        for (int n = 0; n < 16; n++) begin
            int  k;
            bit  pb, sb;
            k  = $urandom_range(0, 9);
            sb = (k == 9);
            pb = sb ? bit'($urandom_range(0, 1)) : (k >= 7);
            out_ready = ($urandom_range(0, 2) == 0);
            run_frame($sformatf("rnd_%0d", n), 8'($urandom_range(0, 255)), pb, sb, 1'b0, -1);
        end
        drain("drain_rnd");

        // Reset in the middle of a frame discards it and empties the FIFO.
        run_frame("pre_rst_a", 8'h11, 1'b0, 1'b0, 1'b0, -1);
        run_frame("pre_rst_b", 8'h22, 1'b0, 1'b0, 1'b0, -1);
        send_bits(build(8'h33, 1'b0, 1'b0), 0, 3, -1, -1);
        reset = 1'b0;
        tick(3);
        chk("mid_rst.fifo_count", fifo_count, 0);
        chk("mid_rst.out_valid", out_valid, 0);
        chk("mid_rst.out_data", out_data, 0);
        mq.delete();
        reset = 1'b1;
        tick(20);
        run_frame("post_rst", 8'h5A, 1'b0, 1'b0, 1'b0, -1);
        drain("drain_post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
